// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: PC width, NOP encoding,
// default boot address, fetch FSM state encodings and the PC increment helper.
package fetch_stage_pkg;

  localparam int PC_WIDTH = 32;
  localparam logic [PC_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    FETCH_S_BOOT    = 2'd0,
    FETCH_S_REQ     = 2'd1,
    FETCH_S_HOLD    = 2'd2,
    FETCH_S_DISCARD = 2'd3
  } fetchState_e;

  // Sequential successor of a PC; wraps modulo 2^32.
  function automatic logic [PC_WIDTH-1:0] pcInc(input logic [PC_WIDTH-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Enable freezes the whole register (clear included),
// clear loads a bubble, otherwise the handed instruction is captured.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clr,
  input  logic [PC_WIDTH-1:0] instrIn,
  input  logic [PC_WIDTH-1:0] pcIn,
  input  logic [PC_WIDTH-1:0] pcPlus4In,
  output logic [PC_WIDTH-1:0] instrOut,
  output logic [PC_WIDTH-1:0] pcOut,
  output logic [PC_WIDTH-1:0] pcPlus4Out,
  output logic                validOut
);

  // IF/ID state: bubble on reset or clear, hold when disabled, else load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instrOut   <= NOP_INSTR;
      pcOut      <= 32'h0000_0000;
      pcPlus4Out <= 32'h0000_0000;
      validOut   <= 1'b0;
    end else if (en) begin
      if (clr) begin
        instrOut   <= NOP_INSTR;
        pcOut      <= 32'h0000_0000;
        pcPlus4Out <= 32'h0000_0000;
        validOut   <= 1'b0;
      end else begin
        instrOut   <= instrIn;
        pcOut      <= pcIn;
        pcPlus4Out <= pcPlus4In;
        validOut   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem request,
// one-entry hold buffer for words arriving while decode is stalled, redirect
// handling and the IF/ID register.
// Optional feature macro: DELAY_SLOT_EN -- the instruction after a taken
// branch executes (delay slot); otherwise it is killed and replaced by a bubble.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stallF,
  input  logic                stallD,
  input  logic                flushD,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [PC_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0] instrD,
  output logic [PC_WIDTH-1:0] pcD,
  output logic [PC_WIDTH-1:0] pc_plus4D,
  output logic                validD
);

  fetchState_e         state_r, stateNext_s;
  logic [PC_WIDTH-1:0] pcF_r, pcFNext_s;
  logic [PC_WIDTH-1:0] imemAddr_r, addrNext_s;
  logic [PC_WIDTH-1:0] holdInstr_r, holdNext_s;
  logic                imemReq_r;
  logic                advance_s, redirAcc_s, wordAvail_s, handover_s;
  logic [PC_WIDTH-1:0] availInstr_s, handInstr_s, seqPc_s;
`ifdef DELAY_SLOT_EN
  logic                pendValid_r, pendValidNext_s;
  logic [PC_WIDTH-1:0] pendPc_r, pendPcNext_s, slotNext_s;
`endif

  // stallD alone also freezes fetch; redirects only count while decode moves
  assign advance_s    = ~(stallF | stallD);
  assign redirAcc_s   = advance_s & redirect_valid;
  assign seqPc_s      = pcInc(pcF_r);
  assign wordAvail_s  = ((state_r == FETCH_S_REQ) & imem_ack) | (state_r == FETCH_S_HOLD);
  assign availInstr_s = (state_r == FETCH_S_HOLD) ? holdInstr_r : imem_rdata;
`ifdef DELAY_SLOT_EN
  // After the delay slot, a latched target beats a same-cycle redirect
  assign slotNext_s   = pendValid_r ? pendPc_r : (redirAcc_s ? redirect_pc : seqPc_s);
`endif

  // Next-state, next-PC and hand-over decisions of the fetch FSM
  always_comb begin
    stateNext_s  = state_r;
    pcFNext_s    = pcF_r;
    addrNext_s   = imemAddr_r;
    holdNext_s   = holdInstr_r;
    handover_s   = 1'b0;
    handInstr_s  = NOP_INSTR;
`ifdef DELAY_SLOT_EN
    pendValidNext_s = pendValid_r;
    pendPcNext_s    = pendPc_r;
`endif
    case (state_r)
      FETCH_S_BOOT: begin
        stateNext_s = FETCH_S_REQ;
        pcFNext_s   = RESET_PC;
        addrNext_s  = RESET_PC;
      end
      FETCH_S_REQ, FETCH_S_HOLD: begin
        if (wordAvail_s && advance_s) begin
          stateNext_s = FETCH_S_REQ;
`ifdef DELAY_SLOT_EN
          handover_s      = 1'b1;
          handInstr_s     = availInstr_s;
          pcFNext_s       = slotNext_s;
          addrNext_s      = slotNext_s;
          pendValidNext_s = 1'b0;
`else
          if (redirect_valid) begin
            // Word in IF is on the wrong path: drop it and refetch at target
            pcFNext_s  = redirect_pc;
            addrNext_s = redirect_pc;
          end else begin
            handover_s  = 1'b1;
            handInstr_s = availInstr_s;
            pcFNext_s   = seqPc_s;
            addrNext_s  = seqPc_s;
          end
`endif
        end else if (wordAvail_s) begin
          holdNext_s  = availInstr_s;
          stateNext_s = FETCH_S_HOLD;
        end else if (redirAcc_s) begin
`ifdef DELAY_SLOT_EN
          // Slot word still in flight: remember where to go after it
          pendValidNext_s = 1'b1;
          pendPcNext_s    = redirect_pc;
`else
          // Request cannot be withdrawn; drain it, then fetch the target
          pcFNext_s   = redirect_pc;
          stateNext_s = FETCH_S_DISCARD;
`endif
        end else begin
          stateNext_s = state_r;
        end
      end
      FETCH_S_DISCARD: begin
        if (redirAcc_s) begin
          pcFNext_s = redirect_pc;
        end else begin
          pcFNext_s = pcF_r;
        end
        if (imem_ack) begin
          addrNext_s  = redirAcc_s ? redirect_pc : pcF_r;
          stateNext_s = FETCH_S_REQ;
        end else begin
          stateNext_s = FETCH_S_DISCARD;
        end
      end
      default: begin
        stateNext_s = FETCH_S_BOOT;
        pcFNext_s   = RESET_PC;
        addrNext_s  = RESET_PC;
      end
    endcase
  end

  // Fetch state, PC, request address/strobe and hold buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= FETCH_S_BOOT;
      pcF_r       <= RESET_PC;
      imemAddr_r  <= RESET_PC;
      imemReq_r   <= 1'b0;
      holdInstr_r <= NOP_INSTR;
    end else begin
      state_r     <= stateNext_s;
      pcF_r       <= pcFNext_s;
      imemAddr_r  <= addrNext_s;
      imemReq_r   <= (stateNext_s == FETCH_S_REQ) || (stateNext_s == FETCH_S_DISCARD);
      holdInstr_r <= holdNext_s;
    end
  end

`ifdef DELAY_SLOT_EN
  // Pending redirect target waiting for the delay-slot word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendValid_r <= 1'b0;
      pendPc_r    <= 32'h0000_0000;
    end else begin
      pendValid_r <= pendValidNext_s;
      pendPc_r    <= pendPcNext_s;
    end
  end
`endif

  assign imem_req  = imemReq_r;
  assign imem_addr = imemAddr_r;

  if_id_reg uIfId (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (~stallD),
    .clr        (flushD | ~handover_s),
    .instrIn    (handInstr_s),
    .pcIn       (pcF_r),
    .pcPlus4In  (seqPc_s),
    .instrOut   (instrD),
    .pcOut      (pcD),
    .pcPlus4Out (pc_plus4D),
    .validOut   (validD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle-exact scenarios, then a randomized run
// with a variable-latency memory, random stalls and branches; a scoreboard
// compares every instruction entering decode with an instruction-stream model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stallF = 1'b0, stallD = 1'b0, flushD = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'h0;
  logic [31:0] instrD, pcD, pc_plus4D;
  logic        validD;

  int checks = 0;
  int errors = 0;
  int popped = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instrD(instrD), .pcD(pcD), .pc_plus4D(pc_plus4D),
    .validD(validD)
  );

  // Program image and branch placement
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  function automatic logic isBranch(input logic [31:0] pc);
    return pc[5:2] == 4'b1010;
  endfunction
  function automatic logic [31:0] brTarget(input logic [31:0] pc);
    logic [7:0] hi;
    hi = pc[15:8] + 8'h35;
    return pc[12] ? 32'hFFFF_FFF0 : {16'h0000, hi, 8'h00};
  endfunction

  // Redirect source: decode-side branch resolution in the random run, direct drive otherwise
  logic        autoBr = 1'b0, dirRedir = 1'b0;
  logic [31:0] dirPc = 32'h0;
  assign redirect_valid = autoBr ? (validD && isBranch(pcD)) : dirRedir;
  assign redirect_pc    = autoBr ? brTarget(pcD) : dirPc;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Memory responder: fixed latency (lat) or random up to latMax per request
  int          lat = 0;
  int unsigned latMax = 0;
  int          remaining = 0;
  logic        reqPrev = 1'b0, ackPrev = 1'b0;
  logic [31:0] outAddr = 32'h0;
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      reqPrev  = 1'b0;
      ackPrev  = 1'b0;
      imem_ack = 1'b0;
    end else begin
      if (imem_req && (!reqPrev || ackPrev)) begin
        remaining = (latMax > 0) ? int'($urandom_range(latMax, 0)) : lat;
        outAddr   = imem_addr;
      end else if (imem_req) begin
        chk("addr_stable", imem_addr, outAddr);
        remaining--;
      end
      imem_ack   = imem_req && (remaining == 0);
      imem_rdata = imem_ack ? memWord(imem_addr) : 32'hDEAD_BEEF;
      reqPrev    = imem_req;
      ackPrev    = imem_ack;
    end
  end

  // Scoreboard: expected decode stream and monitor
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t expQ[$];
  logic monEn = 1'b0;
  logic loaded = 1'b0;

  task automatic fillModel(input int n);
    logic [31:0] pc;
    logic [31:0] slot;
    exp_t e;
    expQ.delete();
    pc = 32'h0000_3000;
    for (int i = 0; i < n; i++) begin
      e.pc = pc; e.instr = memWord(pc);
      expQ.push_back(e);
`ifdef DELAY_SLOT_EN
      if (isBranch(pc)) begin
        slot = pc + 32'd4;
        e.pc = slot; e.instr = memWord(slot);
        expQ.push_back(e);
        pc = brTarget(pc);
      end else begin
        pc = pc + 32'd4;
      end
`else
      slot = pc + 32'd4;
      pc = isBranch(pc) ? brTarget(pc) : slot;
`endif
    end
  endtask

  // Whether the IF/ID register was allowed to load at the last edge
  always @(posedge clk) loaded <= rst_n && !stallD;

  // Compare each newly loaded real instruction against the model stream
  always @(negedge clk) begin
    if (monEn && rst_n && validD && loaded) begin
      if (expQ.size() == 0) begin
        errors++; checks++;
        $display("FAIL sb_empty: unexpected instr at pc %h", pcD);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        popped++;
        chk("sb_pcD", pcD, e.pc);
        chk("sb_instrD", instrD, e.instr);
        chk("sb_pc_plus4D", pc_plus4D, e.pc + 32'd4);
      end
    end
  end

  task automatic checkResetVals(input string tag);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'h0000_3000);
    chk({tag, "_instrD"}, instrD, 32'h0);
    chk({tag, "_pcD"}, pcD, 32'h0);
    chk({tag, "_pc_plus4D"}, pc_plus4D, 32'h0);
    chk({tag, "_validD"}, {31'd0, validD}, 32'd0);
  endtask

  task automatic doReset();
    rst_n = 1'b0; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
    dirRedir = 1'b0; autoBr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkResetVals("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    // Directed: zero-wait stream, stall hold, flush under stall
    lat = 0; latMax = 0;
    doReset();
    @(negedge clk); // c1
    chk("c1_req", {31'd0, imem_req}, 32'd1);
    chk("c1_addr", imem_addr, 32'h3000);
    chk("c1_validD", {31'd0, validD}, 32'd0);
    @(negedge clk); // c2
    chk("c2_addr", imem_addr, 32'h3004);
    chk("c2_pcD", pcD, 32'h3000);
    chk("c2_instrD", instrD, memWord(32'h3000));
    chk("c2_pc_plus4D", pc_plus4D, 32'h3004);
    chk("c2_validD", {31'd0, validD}, 32'd1);
    stallD = 1'b1; stallF = 1'b1;
    @(negedge clk); // c3
    chk("hold_c3_req", {31'd0, imem_req}, 32'd0);
    chk("hold_c3_pcD", pcD, 32'h3000);
    flushD = 1'b1;
    @(negedge clk); // c4
    chk("stallflush_pcD", pcD, 32'h3000);
    chk("stallflush_instrD", instrD, memWord(32'h3000));
    chk("stallflush_validD", {31'd0, validD}, 32'd1);
    chk("hold_c4_req", {31'd0, imem_req}, 32'd0);
    flushD = 1'b0;
    @(negedge clk); // c5
    chk("hold_c5_req", {31'd0, imem_req}, 32'd0);
    stallD = 1'b0; stallF = 1'b0;
    @(negedge clk); // c6
    chk("release_instrD", instrD, memWord(32'h3004));
    chk("release_pcD", pcD, 32'h3004);
    chk("release_req", {31'd0, imem_req}, 32'd1);
    chk("release_addr", imem_addr, 32'h3008);
    lat = 3;
    @(negedge clk); // c7: request 0x300C starts with three wait cycles
    chk("c7_pcD", pcD, 32'h3008);
    chk("c7_addr", imem_addr, 32'h300C);
    dirRedir = 1'b1; dirPc = 32'h4000;
    @(negedge clk); // c8
    dirRedir = 1'b0; lat = 0;
    chk("redir_c8_validD", {31'd0, validD}, 32'd0);
    chk("redir_c8_addr", imem_addr, 32'h300C);
    @(negedge clk); // c9
    chk("redir_c9_req", {31'd0, imem_req}, 32'd1);
    chk("redir_c9_addr", imem_addr, 32'h300C);
    @(negedge clk); // c10
    chk("redir_c10_validD", {31'd0, validD}, 32'd0);
    @(negedge clk); // c11
    chk("redir_c11_addr", imem_addr, 32'h4000);
`ifdef DELAY_SLOT_EN
    chk("slot_pcD", pcD, 32'h300C);
    chk("slot_instrD", instrD, memWord(32'h300C));
    chk("slot_validD", {31'd0, validD}, 32'd1);
`else
    chk("kill_validD", {31'd0, validD}, 32'd0);
`endif
    @(negedge clk); // c12
    chk("target_pcD", pcD, 32'h4000);
    chk("target_instrD", instrD, memWord(32'h4000));
    chk("target_validD", {31'd0, validD}, 32'd1);
    chk("target_addr", imem_addr, 32'h4004);
    flushD = 1'b1;
    @(negedge clk); // c13
    chk("flush_validD", {31'd0, validD}, 32'd0);
    chk("flush_pcD", pcD, 32'h0);
    chk("flush_instrD", instrD, 32'h0);
    chk("flush_pc_plus4D", pc_plus4D, 32'h0);
    flushD = 1'b0;

    // Directed: asynchronous reset while a killed request drains
    lat = 3;
    doReset();
    @(negedge clk); // c1: request 0x3000 waiting
    dirRedir = 1'b1; dirPc = 32'h4000;
    @(negedge clk); // c2
    dirRedir = 1'b0;
    chk("drain_req", {31'd0, imem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetVals("midreset");
    @(negedge clk);
    lat = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerun_req", {31'd0, imem_req}, 32'd1);
    chk("rerun_addr", imem_addr, 32'h3000);
    @(negedge clk);
    chk("rerun_pcD", pcD, 32'h3000);
    chk("rerun_instrD", instrD, memWord(32'h3000));

    // Random run: variable latency, stalls, branches incl. wrap past 2^32
    latMax = 3;
    doReset();
    fillModel(4000);
    autoBr = 1'b1;
    monEn  = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      stallD = ($urandom_range(3, 0) == 0);
      if (stallD) begin
        stallF = ($urandom_range(1, 0) == 1);
        flushD = ($urandom_range(1, 0) == 1);
      end else begin
        stallF = ($urandom_range(7, 0) == 0) && !(validD && isBranch(pcD));
        flushD = 1'b0;
      end
    end
    @(negedge clk);
    stallD = 1'b0; stallF = 1'b0; flushD = 1'b0;
    monEn = 1'b0;
    checks++;
    if (popped < 200) begin
      errors++;
      $display("FAIL progress: got %0d instructions, expected at least 200", popped);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
